// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage to mult/div sequencer request/result bundle.
// master drives requests, slave returns stall/busy and HI/LO results.
interface muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        cancel;
   logic        stall;
   logic        busy;
   logic        result_valid;
   logic [31:0] result_hi;
   logic [31:0] result_lo;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  stall, busy, result_valid, result_hi, result_lo
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output stall, busy, result_valid, result_hi, result_lo
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MULT/MULTU/DIV/DIVU sequencer with a latency-timed
// multiplier and a radix-2 restoring divider feeding HI/LO.
module muldiv_ctrl #(
   parameter int MUL_LAT  = 3,
   parameter int DIV_ITER = 32
) (
   input logic     clk,
   input logic     resetn,
   muldiv_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_MUL, S_DIV_PREP, S_DIV_ITER, S_DIV_FIX, S_DONE
   } state_t;

   localparam logic [5:0] MUL_END  = 6'(MUL_LAT - 1);
   localparam logic [5:0] ITER_END = 6'(DIV_ITER - 1);

   state_t      state, nxt;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [5:0]  cnt;
   logic [31:0] rem, quo, dvs;
   logic        q_neg, r_neg;
   logic [31:0] res_hi, res_lo;
   logic [31:0] out_hi, out_lo;
   logic        accept, is_sgn, div_zero, done_ok;
   logic [31:0] a_abs, b_abs;
   logic [63:0] step, mul_p, mul_in;

   function automatic logic [63:0] mul64(
      input logic [31:0] x, input logic [31:0] y, input logic sgn
   );
      logic signed [65:0] xs, ys, p;
      xs = $signed({{34{sgn & x[31]}}, x});
      ys = $signed({{34{sgn & y[31]}}, y});
      p  = xs * ys;
      return p[63:0];
   endfunction

   function automatic logic [63:0] div_step(
      input logic [31:0] r, input logic [31:0] q, input logic [31:0] d
   );
      logic [33:0] t, diff;
      t    = {1'b0, r, q[31]};
      diff = t - {2'b00, d};
      if (diff[33]) return {t[31:0], q[30:0], 1'b0};
      return {diff[31:0], q[30:0], 1'b1};
   endfunction

   assign accept   = (state == S_IDLE) & bus.start & ~bus.cancel;
   assign is_sgn   = ~op_q[0];
   assign a_abs    = (is_sgn & a_q[31]) ? -a_q : a_q;
   assign b_abs    = (is_sgn & b_q[31]) ? -b_q : b_q;
   assign div_zero = (b_q == 32'd0);
   assign mul_p    = mul64(a_q, b_q, is_sgn);
   assign mul_in   = mul64(bus.src_a, bus.src_b, ~bus.op[0]);

   // PREP performs the first quotient step so the divide fits 34 cycles
   always_comb begin
      if (state == S_DIV_PREP) step = div_step(32'd0, a_abs, b_abs);
      else                     step = div_step(rem, quo, dvs);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:
            if (accept)
               nxt = bus.op[1] ? S_DIV_PREP :
                     (MUL_LAT == 1) ? S_DONE : S_MUL;
         S_MUL:      if (cnt == MUL_END) nxt = S_DONE;
         S_DIV_PREP: nxt = div_zero ? S_DONE : S_DIV_ITER;
         S_DIV_ITER: if (cnt == ITER_END) nxt = S_DIV_FIX;
         S_DIV_FIX:  nxt = S_DONE;
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
      if (bus.cancel && state != S_IDLE) nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
         out_hi <= '0;
         out_lo <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (accept) begin
               op_q <= bus.op;
               a_q  <= bus.src_a;
               b_q  <= bus.src_b;
               cnt  <= 6'd1;
               if (MUL_LAT == 1 && !bus.op[1])
                  {res_hi, res_lo} <= mul_in;
            end
            S_MUL: begin
               cnt              <= cnt + 6'd1;
               {res_hi, res_lo} <= mul_p;
            end
            S_DIV_PREP: begin
               q_neg      <= is_sgn & (a_q[31] ^ b_q[31]);
               r_neg      <= is_sgn & a_q[31];
               dvs        <= b_abs;
               {rem, quo} <= step;
               cnt        <= 6'd1;
               if (div_zero) begin
                  res_hi <= a_q;
                  res_lo <= '1;
               end
            end
            S_DIV_ITER: begin
               {rem, quo} <= step;
               if (cnt != ITER_END) cnt <= cnt + 6'd1;
            end
            S_DIV_FIX: begin
               res_hi <= r_neg ? -rem : rem;
               res_lo <= q_neg ? -quo : quo;
            end
            S_DONE: if (!bus.cancel) begin
               out_hi <= res_hi;
               out_lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

   // a cancelled DONE cycle must neither pulse nor expose the result
   assign done_ok = (state == S_DONE) & ~bus.cancel;

   always_comb begin
      bus.busy         = (state != S_IDLE);
      bus.stall        = accept |
                         ((state != S_IDLE) & (state != S_DONE) & ~bus.cancel);
      bus.result_valid = done_ok;
      bus.result_hi    = done_ok ? res_hi : out_hi;
      bus.result_lo    = done_ok ? res_lo : out_lo;
   end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vectors with a result scoreboard and
// per-cycle stall/valid timing checks.
module tb_muldiv_ctrl;
   logic clk = 1'b0;
   logic resetn;
   muldiv_if bus ();

   muldiv_ctrl #(.MUL_LAT(3), .DIV_ITER(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] sb[$];
   logic [31:0] last_hi = 32'd0;
   logic [31:0] last_lo = 32'd0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_valid: got result_valid=1 expected 0 at %0t",
                        $time);
            end else begin
               e = sb.pop_front();
               chk("sb_hi", bus.result_hi, e[63:32]);
               chk("sb_lo", bus.result_lo, e[31:0]);
            end
         end
      end
   end

   task automatic run_op(input string nm, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input int lat, input bit hold);
      bus.start = 1'b1;
      bus.op    = o;
      bus.src_a = a;
      bus.src_b = b;
      sb.push_back({hi, lo});
      last_hi = hi;
      last_lo = lo;
      @(negedge clk);
      chk({nm, "_stall_c0"}, 32'(bus.stall), 32'd1);
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk);
         #1;
         if (!hold) bus.start = 1'b0;
         @(negedge clk);
         if (c < lat) begin
            chk({nm, "_stall"}, 32'(bus.stall), 32'd1);
            chk({nm, "_novalid"}, 32'(bus.result_valid), 32'd0);
         end else begin
            chk({nm, "_valid"}, 32'(bus.result_valid), 32'd1);
            chk({nm, "_stall_done"}, 32'(bus.stall), 32'd0);
         end
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      resetn     = 1'b0;
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.src_a  = 32'd0;
      bus.src_b  = 32'd0;
      bus.cancel = 1'b0;
      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_valid", 32'(bus.result_valid), 32'd0);
      chk("rst_hi", bus.result_hi, 32'd0);
      chk("rst_lo", bus.result_lo, 32'd0);
      #4;
      resetn = 1'b1;

      run_op("mult", 2'b00, 32'hFFFFFFFD, 32'h7,
             32'hFFFFFFFF, 32'hFFFFFFEB, 3, 1'b0);
      run_op("multu", 2'b01, 32'hFFFFFFFD, 32'h7,
             32'h00000006, 32'hFFFFFFEB, 3, 1'b0);
      run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000,
             32'h40000000, 32'h00000000, 3, 1'b0);
      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFE, 32'h00000001, 3, 1'b0);
      run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h2,
             32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0);
      run_op("divu_100_7", 2'b11, 32'd100, 32'd7,
             32'd2, 32'd14, 34, 1'b0);
      run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE,
             32'd1, 32'hFFFFFFFD, 34, 1'b0);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
             32'h00000000, 32'h80000000, 34, 1'b0);
      run_op("divu_big", 2'b11, 32'hFFFFFFFF, 32'h10,
             32'h0000000F, 32'h0FFFFFFF, 34, 1'b0);
      run_op("divu_5_0", 2'b11, 32'd5, 32'd0,
             32'd5, 32'hFFFFFFFF, 2, 1'b0);
      run_op("div_m5_0", 2'b10, 32'hFFFFFFFB, 32'd0,
             32'hFFFFFFFB, 32'hFFFFFFFF, 2, 1'b0);

      // start held through a busy MULT, then back-to-back DIVU
      run_op("mult_hold", 2'b00, 32'd6, 32'hFFFFFFF9,
             32'hFFFFFFFF, 32'hFFFFFFD6, 3, 1'b1);
      run_op("divu_b2b", 2'b11, 32'd1000, 32'd3,
             32'd1, 32'd333, 34, 1'b0);

      // cancel at cycle 15 of a DIVU
      bus.start = 1'b1;
      bus.op    = 2'b11;
      bus.src_a = 32'd12345;
      bus.src_b = 32'd11;
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      bus.cancel = 1'b1;
      @(negedge clk);
      chk("cancel_stall", 32'(bus.stall), 32'd0);
      chk("cancel_novalid", 32'(bus.result_valid), 32'd0);
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      @(negedge clk);
      chk("cancel_busy", 32'(bus.busy), 32'd0);
      chk("cancel_hi", bus.result_hi, last_hi);
      chk("cancel_lo", bus.result_lo, last_lo);
      repeat (40) @(posedge clk);
      #1;

      // start with cancel in IDLE is refused
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      bus.op     = 2'b01;
      @(negedge clk);
      chk("sc_stall", 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      @(negedge clk);
      chk("sc_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;

      // reset asserted at cycle 10 of a DIV
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.src_a = 32'd77;
      bus.src_b = 32'd5;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      resetn = 1'b0;
      #1;
      chk("rstd_busy", 32'(bus.busy), 32'd0);
      chk("rstd_stall", 32'(bus.stall), 32'd0);
      chk("rstd_valid", 32'(bus.result_valid), 32'd0);
      chk("rstd_hi", bus.result_hi, 32'd0);
      chk("rstd_lo", bus.result_lo, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("rstd_idle", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      run_op("multu_post", 2'b01, 32'h00010000, 32'h00030000,
             32'h00000003, 32'h00000000, 3, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
